audio_voice_mixer: RTL and testbench

Parametrised per-sample audio processor between the Audio_Controller FIFOs and the rest of the voice-changer design. It pulls one frame (all channels) from the ADC side when a DAC slot is free. It computes the output frame in one of five modes: bypass, tone, PCM playback, tone+mic mix, or echo. It then pushes the frame with a single registered read/write strobe. It generalises the fixed two-channel, combinational glue to N channels, configurable widths, saturating arithmetic, volume and a delay line.

---
 rtl/audio_voice_mixer.sv | 156 +++++++++++++++
 tb/tb_audio_voice_mixer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_voice_mixer.sv
// Per-frame audio processor between the ADC and DAC FIFOs: bypass, tone, PCM playback,
// tone+mic mix or echo, with saturating arithmetic, volume shift and a per-channel delay line.
module audio_voice_mixer #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PCM_W    = 16,
    parameter int unsigned PERIOD_W = 19,
    parameter int          TONE_AMP = 10000000,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               mode,
    input  logic [PERIOD_W-1:0]      tone_period,
    input  logic [2:0]               vol_shift,
    input  logic [PCM_W-1:0]         pcm_sample,
    input  logic                     audio_in_available,
    input  logic                     audio_out_allowed,
    input  logic [N_CH*DATA_W-1:0]   audio_in_data,
    output logic                     read_audio_in,
    output logic                     write_audio_out,
    output logic [N_CH*DATA_W-1:0]   audio_out_data,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam logic [DATA_W-1:0] AmpPos = DATA_W'(TONE_AMP);
    localparam logic [DATA_W-1:0] AmpNeg = ~AmpPos + DATA_W'(1);

    typedef enum logic [1:0] {StIdle, StCapture, StStrobe} state_e;

    state_e                   state_q, state_d;
    logic [PERIOD_W-1:0]      tcnt_q, tcnt_d;
    logic                     tone_pos_q, tone_pos_d;
    logic [2:0]               mode_q, mode_d;
    logic [2:0]               vol_q, vol_d;
    logic [AW-1:0]            wp_q, wp_d;
    logic [FW-1:0]            fill_q, fill_d;
    logic                     strobe_q, strobe_d;
    logic [N_CH*DATA_W-1:0]   out_q, out_d;
    logic [N_CH*DATA_W-1:0]   frame_c;
    logic [DATA_W-1:0]        tone_val;
    logic [DATA_W-1:0]        pcm_ext;
    logic                     fill_full;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Sign bits disagree only when the sum left the representable range.
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] chan_result(input logic [2:0]        m,
                                                      input logic [2:0]        v,
                                                      input logic [DATA_W-1:0] din,
                                                      input logic [DATA_W-1:0] dly,
                                                      input logic [DATA_W-1:0] tone,
                                                      input logic [DATA_W-1:0] pcm);
        logic [DATA_W-1:0] r;
        case (m)
            3'd1:    r = tone;
            3'd2:    r = pcm;
            3'd3:    r = sat_add(din, tone);
            3'd4:    r = sat_add(din, DATA_W'($signed(dly) >>> 1));
            default: r = din;
        endcase
        return DATA_W'($signed(r) >>> v);
    endfunction

    assign tone_val  = tone_pos_q ? AmpPos : AmpNeg;
    assign pcm_ext   = {pcm_sample, {(DATA_W-PCM_W){1'b0}}};
    assign fill_full = (fill_q == FW'(DEPTH));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];

        // Echo RAM holds no reset; reads before a full lap are masked by fill_full.
        always_ff @(posedge clk) begin
            if (state_q == StCapture) begin
                mem_q[wp_q] <= audio_in_data[g*DATA_W +: DATA_W];
            end
        end

        assign frame_c[g*DATA_W +: DATA_W] =
            chan_result(mode_q, vol_q, audio_in_data[g*DATA_W +: DATA_W],
                        fill_full ? mem_q[wp_q] : '0, tone_val, pcm_ext);
    end

    always_comb begin
        tcnt_d     = (tcnt_q == tone_period) ? '0 : tcnt_q + PERIOD_W'(1);
        tone_pos_d = (tcnt_q == tone_period) ? ~tone_pos_q : tone_pos_q;
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        vol_d    = vol_q;
        wp_d     = wp_q;
        fill_d   = fill_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (audio_in_available && audio_out_allowed) begin
                    mode_d  = mode;
                    vol_d   = vol_shift;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                out_d    = frame_c;
                wp_d     = wp_q + AW'(1);
                fill_d   = fill_full ? fill_q : fill_q + FW'(1);
                strobe_d = 1'b1;
                state_d  = StStrobe;
            end
            StStrobe: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            tone_pos_q <= 1'b0;
            mode_q     <= '0;
            vol_q      <= '0;
            wp_q       <= '0;
            fill_q     <= '0;
            strobe_q   <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            tone_pos_q <= tone_pos_d;
            mode_q     <= mode_d;
            vol_q      <= vol_d;
            wp_q       <= wp_d;
            fill_q     <= fill_d;
            strobe_q   <= strobe_d;
            out_q      <= out_d;
        end
    end

    assign read_audio_in   = strobe_q;
    assign write_audio_out = strobe_q;
    assign audio_out_data  = out_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Self-checking bench for audio_voice_mixer: frame-level reference model checked every cycle,
// plus directed frames with hand-computed results.
module tb_audio_voice_mixer;

    localparam int DEP = 4;
    localparam longint AMP = 10000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  mode = '0;
    logic [18:0] tone_period = 19'd100;
    logic [2:0]  vol_shift = '0;
    logic [15:0] pcm_sample = '0;
    logic        audio_in_available = 1'b0;
    logic        audio_out_allowed = 1'b0;
    logic [63:0] audio_in_data = '0;
    logic        read_audio_in, write_audio_out, busy;
    logic [63:0] audio_out_data;

    int errors = 0;
    int checks = 0;

    audio_voice_mixer #(
        .N_CH(2), .DATA_W(32), .PCM_W(16), .PERIOD_W(19), .TONE_AMP(10000000), .DEPTH(DEP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mode(mode),
        .tone_period(tone_period),
        .vol_shift(vol_shift),
        .pcm_sample(pcm_sample),
        .audio_in_available(audio_in_available),
        .audio_out_allowed(audio_out_allowed),
        .audio_in_data(audio_in_data),
        .read_audio_in(read_audio_in),
        .write_audio_out(write_audio_out),
        .audio_out_data(audio_out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_tcnt = 0;
    bit          m_pos = 0;
    bit          m_acc = 0, m_cap = 0, acc_now = 0, cap_now = 0;
    logic [2:0]  m_mode = '0, m_vol = '0;
    longint      h0[$], h1[$];
    longint      din0, din1, d0, d1;
    bit          exp_strobe = 0, exp_busy = 0;
    logic [63:0] exp_out = '0;

    function automatic longint clamp(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint model_chan(input logic [2:0] m, input logic [2:0] v,
                                          input longint din, input longint dly, input bit pos,
                                          input logic [15:0] pcm);
        longint t, r;
        t = pos ? AMP : -AMP;
        case (m)
            3'd1:    r = t;
            3'd2:    r = longint'($signed(pcm)) * 65536;
            3'd3:    r = clamp(din + t);
            3'd4:    r = clamp(din + (dly >>> 1));
            default: r = din;
        endcase
        return r >>> v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tcnt = 0; m_pos = 0; m_acc = 0; m_cap = 0; m_mode = '0; m_vol = '0;
            h0.delete(); h1.delete();
            exp_strobe = 0; exp_busy = 0; exp_out = '0;
        end else begin
            cap_now = m_acc;
            if (cap_now) begin
                din0 = longint'($signed(audio_in_data[31:0]));
                din1 = longint'($signed(audio_in_data[63:32]));
                d0 = (h0.size() == DEP) ? h0[0] : 0;
                d1 = (h1.size() == DEP) ? h1[0] : 0;
                h0.push_back(din0); h1.push_back(din1);
                if (h0.size() > DEP) void'(h0.pop_front());
                if (h1.size() > DEP) void'(h1.pop_front());
                exp_out = {32'(model_chan(m_mode, m_vol, din1, d1, m_pos, pcm_sample)),
                           32'(model_chan(m_mode, m_vol, din0, d0, m_pos, pcm_sample))};
            end
            acc_now = !m_acc && !m_cap && audio_in_available && audio_out_allowed;
            if (acc_now) begin
                m_mode = mode;
                m_vol  = vol_shift;
            end
            exp_strobe = cap_now;
            exp_busy   = acc_now || cap_now;
            m_acc = acc_now;
            m_cap = cap_now;
            if (m_tcnt == int'(tone_period)) begin
                m_tcnt = 0;
                m_pos  = !m_pos;
            end else begin
                m_tcnt++;
            end
        end
    end

    always @(negedge clk) begin
        check("read_audio_in", read_audio_in, exp_strobe);
        check("write_audio_out", write_audio_out, exp_strobe);
        check("busy", busy, exp_busy);
        check("audio_out_data", audio_out_data, exp_out);
    end

    // ---------------- directed stimulus ----------------
    task automatic frame(input logic [2:0] m, input logic [2:0] v, input logic [31:0] c1,
                         input logic [31:0] c0, output logic [63:0] res);
        int lat;
        @(negedge clk);
        mode = m; vol_shift = v; audio_in_data = {c1, c0};
        audio_in_available = 1'b1; audio_out_allowed = 1'b1;
        lat = 0; res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (write_audio_out) begin
                lat = i;
                res = audio_out_data;
                break;
            end
        end
        audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        check("frame_latency", 64'(lat), 64'd2);
    endtask

    task automatic wait_tone(input bit pos);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (m_pos == pos && m_tcnt < 100) begin
                ok = 1;
                break;
            end
        end
        check("tone_wait", 64'(ok), 64'd1);
    endtask

    logic [63:0] res;
    int          cnt;
    int          ev[6] = '{100, 200, 300, 400, 550, 700};

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", audio_out_data, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_strobe", read_audio_in | write_audio_out, 1'b0);
        reset_n = 1'b1;

        frame(3'd0, 3'd0, 32'h0000_1234, 32'hFFFF_FF00, res);
        check("bypass", res, 64'h0000_1234_FFFF_FF00);

        pcm_sample = 16'h8001;
        frame(3'd2, 3'd4, 32'h1111_1111, 32'h2222_2222, res);
        check("pcm_vol4", res, 64'hF800_1000_F800_1000);

        tone_period = 19'd3;
        for (int i = 0; i < 3; i++) begin
            frame(3'd1, 3'd0, 32'h0, 32'h0, res);
            check("tone_level", 64'(res[31:0] == 32'(AMP) || res[31:0] == 32'(-AMP)), 64'd1);
            frame(3'd1, 3'd2, 32'h0, 32'h0, res);
            check("tone_vol2", 64'(res[63:32] == 32'd2500000 || res[63:32] == 32'(-2500000)),
                  64'd1);
        end

        tone_period = 19'd200;
        wait_tone(1'b1);
        frame(3'd3, 3'd0, 32'h7FFF_FFF0, 32'h7FFF_FFF0, res);
        check("mix_sat_pos", res, 64'h7FFF_FFFF_7FFF_FFFF);
        wait_tone(1'b0);
        frame(3'd3, 3'd0, 32'h8000_0005, 32'h8000_0005, res);
        check("mix_sat_neg", res, 64'h8000_0000_8000_0000);
        wait_tone(1'b1);
        frame(3'd3, 3'd1, 32'd100, 32'(-100), res);
        check("mix_plain", res, {32'(longint'(AMP + 100) >>> 1), 32'(longint'(AMP - 100) >>> 1)});

        @(negedge clk);
        mode = 3'd0; vol_shift = 3'd0; audio_in_data = 64'h0000_00AB_0000_00CD;
        audio_in_available = 1'b1; audio_out_allowed = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (write_audio_out) cnt++;
        end
        check("no_strobe_blocked", 64'(cnt), 64'd0);
        audio_out_allowed = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (write_audio_out) cnt++;
        end
        audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        check("strobe_rate", 64'(cnt), 64'd4);

        @(negedge clk);
        mode = 3'd4; audio_in_data = 64'h0000_0077_0000_0066;
        audio_in_available = 1'b1; audio_out_allowed = 1'b1;
        @(negedge clk);
        check("midframe_busy_before", busy, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("midframe_rst_strobe", read_audio_in | write_audio_out, 1'b0);
        check("midframe_rst_busy", busy, 1'b0);
        check("midframe_rst_out", audio_out_data, 64'd0);
        audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            frame(3'd4, 3'd0, 32'(-(i + 1) * 100), 32'((i + 1) * 100), res);
            check($sformatf("echo_%0d", i), res, {32'(-ev[i]), 32'(ev[i])});
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
